ff_bank: RTL and testbench
==========================

# ff_bank

Parametrised multi-channel flip-flop bank: the next generation of the single SR flip-flop. It provides WIDTH independent storage bits sharing one clock, with a run-time-selectable function (SR, JK, D, T), a deterministic policy for the SR 1-1 condition, a synchronous parallel load, and per-channel sticky illegal-input flags. It sits in control paths that need registered set/clear/toggle state with defined behaviour for every input combination.

## Interface
- WIDTH, 8, number of independent channels (1..64)
- SR11_POLICY, 0, SR-mode response to s=r=1: 0 hold, 1 set, 2 reset; any other value is an elaboration error
- CNT_W, 8, width of illegal-event counter (2..16)
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- en  input  1  function enable; 0 = all channels hold
- load  input  1  synchronous parallel load, overrides en/mode
- load_val  input  WIDTH  value written to q on load
- mode  input  2  00 SR, 01 JK, 10 D, 11 T (global, all channels)
- a  input  WIDTH  per channel: s (SR), j (JK), d (D), t (T)
- b  input  WIDTH  per channel: r (SR), k (JK), ignored in D/T
- clr_err  input  1  synchronous clear of err and illegal_cnt
- q  output  WIDTH  registered channel state
- err  output  WIDTH  sticky per-channel SR 1-1 flag
- illegal_cnt  output  CNT_W  saturating count of cycles with any SR 1-1 event

## Operation
- Priority per rising edge: rst > load > (en and mode function) > hold.
- load=1: q <= load_val; mode, a, b, en ignored; no illegal detection.
- en=0, load=0: q holds; no illegal detection.
- en=1, load=0, per channel i:
  - SR: 00 hold, 01 q=0, 10 q=1, 11 per SR11_POLICY. Never produces X.
  - JK: 00 hold, 01 q=0, 10 q=1, 11 q=~q.
  - D: q=a[i].
  - T: a[i]=1 toggles, 0 holds.
- Illegal event: mode=SR, en=1, load=0, a[i]=b[i]=1. This sets err[i] regardless of SR11_POLICY.
- err[i] stays set until clr_err=1. If clr_err and a new event on channel i occur in the same cycle, set wins: err[i]=1 afterwards.
- illegal_cnt increments by 1 per cycle in which at least one channel has an illegal event, not once per channel.
- illegal_cnt saturates at 2^CNT_W-1.
- clr_err alone resets illegal_cnt to 0. clr_err with an event in the same cycle gives illegal_cnt=1.
- Mode changes take effect at the next edge; there is no pipeline and no transient state.

## Timing
- Reset values: q=0, err=0, illegal_cnt=0, applied immediately on rst assertion, independent of clk.
- rst deassertion: the first functional edge is the first rising clk with rst low. Reset mid-operation discards all state, including saturated counts.
- Latency: inputs sampled at edge N are visible on q, err and illegal_cnt after edge N. All outputs are registered; there are no combinational paths from inputs to outputs.
- Throughput: one operation per cycle per channel; channels are fully independent except for the shared en, load, mode and clr_err.

## Configuration
- FF_BANK_ILLEGAL_CNT_EN defined: illegal_cnt counter logic is present as described.
- Not defined: illegal_cnt is tied to 0 and has no counter flops. err flags and SR11_POLICY behaviour are unchanged.

## Test plan
- Reset and load, WIDTH=4: assert rst mid-run -> q=0000, err=0000, illegal_cnt=0 immediately, before any clock edge; then load=1, load_val=1010 -> q=1010 after one edge.
- SR mode: q=0000, a=0011, b=0101, en=1 -> q=0010 with SR11_POLICY=0, err=0001, illegal_cnt=1; same stimulus with SR11_POLICY=1 -> q=0011; with SR11_POLICY=2 -> q=0010.
- JK/T toggling: q=0101, mode=JK, a=b=1111 for 3 cycles -> q=1010, 0101, 1010. Then mode=T, a=0011 -> q=1001. Then en=0 -> q=1001 holds.
- Load priority: mode=D, en=1, a=1111, load=1, load_val=0110 -> q=0110, no err set. Then load=0 -> q=1111.
- Counter saturation (CNT_W=2): SR mode, a=b=0001 for 5 cycles -> illegal_cnt=1,2,3,3,3.
- Clear versus event: clr_err=1 in the same cycle as a new event on channel 2 only -> err=0100, illegal_cnt=1. clr_err=1 with no event -> err=0000, illegal_cnt=0. With FF_BANK_ILLEGAL_CNT_EN undefined -> illegal_cnt=0 throughout.

Source files
------------

// File: rtl/ff_bank.sv
// Purpose     : WIDTH-channel flip-flop bank with run-time SR/JK/D/T function, parallel load, sticky SR 1-1 flags.
// Latency     : 1 cycle; inputs sampled at a rising clk edge appear on q/err/illegal_cnt right after that edge.
// Backpressure: none; every channel accepts one operation per cycle.
//
// Ports:
//   clk, rst       rising-edge clock; asynchronous active-high reset (q, err, illegal_cnt -> 0)
//   en             function enable; low = all channels hold
//   load, load_val synchronous parallel load, overrides en/mode, no illegal detection
//   mode           00 SR, 01 JK, 10 D, 11 T (shared by all channels)
//   a, b           per channel s/r (SR), j/k (JK), d (D), t (T); b ignored in D/T
//   clr_err        synchronous clear of err and illegal_cnt (a same-cycle event wins)
//   q              registered channel state
//   err            sticky per-channel SR 1-1 flag
//   illegal_cnt    saturating count of cycles with at least one SR 1-1 event
//
// Build option: define FF_BANK_ILLEGAL_CNT_EN to build the illegal_cnt counter;
// otherwise illegal_cnt is tied to 0 and no counter flops exist.

module ff_bank #(
    parameter int WIDTH       = 8,
    parameter int SR11_POLICY = 0,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] err,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    // Reject unsupported configurations at elaboration time.
    generate
        if (SR11_POLICY < 0 || SR11_POLICY > 2) begin : g_bad_policy
            $error("ff_bank: SR11_POLICY must be 0, 1 or 2");
        end
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $error("ff_bank: WIDTH must be in 1..64");
        end
        if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
            $error("ff_bank: CNT_W must be in 2..16");
        end
    endgenerate

    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] ill_vec;   // channels with an SR 1-1 event this cycle

    always_comb begin
        q_nxt   = q;
        ill_vec = '0;
        if (load) begin
            q_nxt = load_val;
        end else if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                case (mode)
                    MODE_SR: begin
                        case ({a[i], b[i]})
                            2'b01:   q_nxt[i] = 1'b0;
                            2'b10:   q_nxt[i] = 1'b1;
                            2'b11: begin
                                // Flag the event regardless of how the policy resolves q.
                                ill_vec[i] = 1'b1;
                                if (SR11_POLICY == 1)
                                    q_nxt[i] = 1'b1;
                                else if (SR11_POLICY == 2)
                                    q_nxt[i] = 1'b0;
                                else
                                    q_nxt[i] = q[i];
                            end
                            default: q_nxt[i] = q[i];
                        endcase
                    end
                    MODE_JK: begin
                        case ({a[i], b[i]})
                            2'b01:   q_nxt[i] = 1'b0;
                            2'b10:   q_nxt[i] = 1'b1;
                            2'b11:   q_nxt[i] = ~q[i];
                            default: q_nxt[i] = q[i];
                        endcase
                    end
                    MODE_D:  q_nxt[i] = a[i];
                    MODE_T:  q_nxt[i] = q[i] ^ a[i];
                    default: q_nxt[i] = q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= '0;
            err <= '0;
        end else begin
            q   <= q_nxt;
            // Clear first, then OR in new events so a same-cycle event survives the clear.
            err <= (clr_err ? '0 : err) | ill_vec;
        end
    end

`ifdef FF_BANK_ILLEGAL_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_nxt;

    // One increment per cycle with any event, not per channel.
    always_comb begin
        cnt_base = clr_err ? '0 : illegal_cnt;
        cnt_nxt  = cnt_base;
        if ((|ill_vec) && (cnt_base != CNT_MAX))
            cnt_nxt = cnt_base + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            illegal_cnt <= '0;
        else
            illegal_cnt <= cnt_nxt;
    end
`else
    assign illegal_cnt = '0;
`endif

endmodule

// File: tb/tb_ff_bank.sv
// Purpose     : self-checking bench for ff_bank; three instances (SR11_POLICY 0/1/2, WIDTH=4, CNT_W=2) share stimulus.
// Latency     : outputs sampled 1 time unit after each rising clk edge.
// Backpressure: not applicable.

module tb_ff_bank;

`ifdef FF_BANK_ILLEGAL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam int CNT_MAX = 3;   // 2^CNT_W-1 for CNT_W=2

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic [1:0] mode;
    logic [3:0] a;
    logic [3:0] b;
    logic       clr_err;

    logic [3:0] q0, q1, q2;
    logic [3:0] err0, err1, err2;
    logic [1:0] cnt0, cnt1, cnt2;

    ff_bank #(.WIDTH(4), .SR11_POLICY(0), .CNT_W(2)) u_p0 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .mode(mode),
        .a(a), .b(b), .clr_err(clr_err), .q(q0), .err(err0), .illegal_cnt(cnt0));
    ff_bank #(.WIDTH(4), .SR11_POLICY(1), .CNT_W(2)) u_p1 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .mode(mode),
        .a(a), .b(b), .clr_err(clr_err), .q(q1), .err(err1), .illegal_cnt(cnt1));
    ff_bank #(.WIDTH(4), .SR11_POLICY(2), .CNT_W(2)) u_p2 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .mode(mode),
        .a(a), .b(b), .clr_err(clr_err), .q(q2), .err(err2), .illegal_cnt(cnt2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0] m_q [3];
    logic [3:0] m_err;
    int         m_cnt;

    function automatic logic next_bit(input logic [1:0] md, input int pol,
                                      input logic qb, input logic ab, input logic bb);
        if (md == 2'd2) return ab;          // D
        if (md == 2'd3) return qb ^ ab;     // T
        if (ab && !bb) return 1'b1;         // set
        if (!ab && bb) return 1'b0;         // reset
        if (!ab && !bb) return qb;          // hold
        if (md == 2'd1) return ~qb;         // JK toggle
        if (pol == 1) return 1'b1;          // SR 1-1 policy
        if (pol == 2) return 1'b0;
        return qb;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 3; p++) m_q[p] = 4'b0;
        m_err = 4'b0;
        m_cnt = 0;
    endtask

    // Advance one clock and update the model from the inputs present at the edge.
    task automatic step();
        logic [3:0] ev;
        ev = (!load && en && mode == 2'd0) ? (a & b) : 4'b0;
        @(posedge clk);
        for (int p = 0; p < 3; p++) begin
            if (load)
                m_q[p] = load_val;
            else if (en)
                for (int i = 0; i < 4; i++)
                    m_q[p][i] = next_bit(mode, p, m_q[p][i], a[i], b[i]);
        end
        if (clr_err) begin
            m_err = 4'b0;
            m_cnt = 0;
        end
        m_err = m_err | ev;
        if (ev != 4'b0) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        #1;
    endtask

    task automatic check_model(input string tag);
        int ec;
        ec = CNT_EN ? m_cnt : 0;
        check({tag, "_q0"}, q0, m_q[0]);
        check({tag, "_q1"}, q1, m_q[1]);
        check({tag, "_q2"}, q2, m_q[2]);
        check({tag, "_err"}, err0 | err1 | err2, m_err);
        check({tag, "_err_eq"}, {err0, err1}, {err2, err2});
        check({tag, "_cnt0"}, cnt0, ec);
        check({tag, "_cnt12"}, {cnt1, cnt2}, {ec[1:0], ec[1:0]});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_q"}, {q0, q1, q2}, 12'h000);
        check({tag, "_err"}, {err0, err1, err2}, 12'h000);
        check({tag, "_cnt"}, {cnt0, cnt1, cnt2}, 6'h00);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       load;
        logic [3:0] load_val;
        logic       en;
        logic [1:0] mode;
        logic [3:0] a;
        logic [3:0] b;
        logic       clr;
        logic [3:0] eq0;
        logic [3:0] eq1;
        logic [3:0] eq2;
        logic [3:0] eerr;
        int         ecnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ld, input logic [3:0] lv, input logic e, input logic [1:0] md,
                       input logic [3:0] va, input logic [3:0] vb, input logic c,
                       input logic [3:0] x0, input logic [3:0] x1, input logic [3:0] x2,
                       input logic [3:0] xe, input int xc);
        vec_t v;
        v.load = ld; v.load_val = lv; v.en = e; v.mode = md; v.a = va; v.b = vb; v.clr = c;
        v.eq0 = x0; v.eq1 = x1; v.eq2 = x2; v.eerr = xe; v.ecnt = xc;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; load_val = 4'b0; mode = 2'b0;
        a = 4'b0; b = 4'b0; clr_err = 1'b0;
        model_reset();

        // load, ld_val, en, mode, a, b, clr, q(pol0), q(pol1), q(pol2), err, cnt
        add(1, 4'b1010, 0, 2'd0, 4'b0000, 4'b0000, 0, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 0);
        add(1, 4'b0000, 0, 2'd0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        add(0, 4'b0000, 1, 2'd0, 4'b0011, 4'b0101, 0, 4'b0010, 4'b0011, 4'b0010, 4'b0001, 1);
        add(1, 4'b0101, 0, 2'd0, 4'b0000, 4'b0000, 0, 4'b0101, 4'b0101, 4'b0101, 4'b0001, 1);
        add(0, 4'b0000, 1, 2'd1, 4'b1111, 4'b1111, 0, 4'b1010, 4'b1010, 4'b1010, 4'b0001, 1);
        add(0, 4'b0000, 1, 2'd1, 4'b1111, 4'b1111, 0, 4'b0101, 4'b0101, 4'b0101, 4'b0001, 1);
        add(0, 4'b0000, 1, 2'd1, 4'b1111, 4'b1111, 0, 4'b1010, 4'b1010, 4'b1010, 4'b0001, 1);
        add(0, 4'b0000, 1, 2'd3, 4'b0011, 4'b0000, 0, 4'b1001, 4'b1001, 4'b1001, 4'b0001, 1);
        add(0, 4'b0000, 0, 2'd3, 4'b1111, 4'b0000, 0, 4'b1001, 4'b1001, 4'b1001, 4'b0001, 1);
        add(1, 4'b0110, 1, 2'd2, 4'b1111, 4'b1111, 0, 4'b0110, 4'b0110, 4'b0110, 4'b0001, 1);
        add(0, 4'b0000, 1, 2'd2, 4'b1111, 4'b1111, 0, 4'b1111, 4'b1111, 4'b1111, 4'b0001, 1);
        add(0, 4'b0000, 0, 2'd0, 4'b1111, 4'b1111, 1, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 0);
        add(0, 4'b0000, 1, 2'd0, 4'b0001, 4'b0001, 0, 4'b1111, 4'b1111, 4'b1110, 4'b0001, 1);
        add(0, 4'b0000, 1, 2'd0, 4'b0001, 4'b0001, 0, 4'b1111, 4'b1111, 4'b1110, 4'b0001, 2);
        add(0, 4'b0000, 1, 2'd0, 4'b0001, 4'b0001, 0, 4'b1111, 4'b1111, 4'b1110, 4'b0001, 3);
        add(0, 4'b0000, 1, 2'd0, 4'b0001, 4'b0001, 0, 4'b1111, 4'b1111, 4'b1110, 4'b0001, 3);
        add(0, 4'b0000, 1, 2'd0, 4'b0001, 4'b0001, 0, 4'b1111, 4'b1111, 4'b1110, 4'b0001, 3);
        add(0, 4'b0000, 1, 2'd0, 4'b0100, 4'b0100, 1, 4'b1111, 4'b1111, 4'b1010, 4'b0100, 1);
        add(0, 4'b0000, 0, 2'd0, 4'b0100, 4'b0100, 1, 4'b1111, 4'b1111, 4'b1010, 4'b0000, 0);

        // Reset applied at time 0 must be visible before any clock edge.
        #1;
        check_zero("rst_init");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[k]) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            load = vecs[k].load; load_val = vecs[k].load_val; en = vecs[k].en;
            mode = vecs[k].mode; a = vecs[k].a; b = vecs[k].b; clr_err = vecs[k].clr;
            step();
            check({tag, "_q0"}, q0, vecs[k].eq0);
            check({tag, "_q1"}, q1, vecs[k].eq1);
            check({tag, "_q2"}, q2, vecs[k].eq2);
            check({tag, "_err"}, err0, vecs[k].eerr);
            check({tag, "_cnt"}, cnt0, CNT_EN ? vecs[k].ecnt : 0);
        end

        // Randomised traffic against the model, biased toward SR to exercise events.
        for (int n = 0; n < 400; n++) begin
            load     = ($urandom_range(0, 9) == 0);
            load_val = 4'($urandom);
            en       = ($urandom_range(0, 5) != 0);
            mode     = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0;
            a        = 4'($urandom);
            b        = 4'($urandom);
            clr_err  = ($urandom_range(0, 15) == 0);
            step();
            check_model($sformatf("rnd%0d", n));
        end

        // Saturate the counter and set flags, then assert reset mid-cycle.
        load = 1'b1; load_val = 4'b1011; en = 1'b1; clr_err = 1'b0;
        step();
        load = 1'b0; mode = 2'd0; a = 4'b1111; b = 4'b1111;
        for (int n = 0; n < 4; n++) step();
        check_model("pre_rst");
        a = 4'b0; b = 4'b0; en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_zero("rst_async");
        model_reset();
        @(posedge clk); #1;
        check_zero("rst_held");
        rst = 1'b0;

        // First functional edge after reset release.
        load = 1'b1; load_val = 4'b0110;
        step();
        check_model("post_rst_load");
        load = 1'b0; en = 1'b1; mode = 2'd0; a = 4'b1000; b = 4'b1000;
        step();
        check_model("post_rst_sr11");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
